// File: rtl/floating_mult.sv
// IEEE-754 binary32 multiplier, round-toward-zero, handles subnormals/zeros/Inf/NaN.
// Latency 2 cycles (operand register, result register), one operand pair per cycle.
// No backpressure: free-running pipeline; every cycle's inputs produce a result 2 cycles later.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset; clears both pipeline stages and o_res
//   i_a/i_b  binary32 operands, sampled every cycle
//   o_res    binary32 product, registered
module floating_mult (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_res
);

    // Stage-1 operand registers and stage-2 result register
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_res;

    // Operand decode
    logic        w_s;
    logic [7:0]  w_xa;
    logic [7:0]  w_xb;
    logic [22:0] w_fa;
    logic [22:0] w_fb;
    logic        w_nan_a;
    logic        w_nan_b;
    logic        w_inf_a;
    logic        w_inf_b;
    logic        w_zero_a;
    logic        w_zero_b;
    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic [23:0] w_ma;
    logic [23:0] w_mb;

    // Datapath
    logic signed [11:0] w_e0;
    logic               w_flush;
    logic [47:0]        w_p;
    logic signed [11:0] w_e;
    logic signed [11:0] w_lz;
    logic signed [11:0] w_sh;
    logic [31:0]        w_res;

    assign w_s  = r_a[31] ^ r_b[31];
    assign w_xa = r_a[30:23];
    assign w_xb = r_b[30:23];
    assign w_fa = r_a[22:0];
    assign w_fb = r_b[22:0];

    assign w_nan_a  = (w_xa == 8'hFF) && (w_fa != 23'd0);
    assign w_nan_b  = (w_xb == 8'hFF) && (w_fb != 23'd0);
    assign w_inf_a  = (w_xa == 8'hFF) && (w_fa == 23'd0);
    assign w_inf_b  = (w_xb == 8'hFF) && (w_fb == 23'd0);
    assign w_zero_a = (w_xa == 8'h00) && (w_fa == 23'd0);
    assign w_zero_b = (w_xb == 8'h00) && (w_fb == 23'd0);

    // Subnormals live at exponent 1 without the hidden bit
    assign w_ea = (w_xa == 8'h00) ? 8'd1 : w_xa;
    assign w_eb = (w_xb == 8'h00) ? 8'd1 : w_xb;
    assign w_ma = {w_xa != 8'h00, w_fa};
    assign w_mb = {w_xb != 8'h00, w_fb};

    // Unnormalised result exponent; the flush decision is taken on this raw value
    assign w_e0    = $signed({4'b0000, w_ea}) + $signed({4'b0000, w_eb}) - 12'sd127;
    assign w_flush = (w_e0 <= -12'sd23);

    always_comb begin
        w_p   = 48'(w_ma) * 48'(w_mb);
        w_e   = w_e0;
        w_lz  = '0;
        w_sh  = '0;
        w_res = '0;

        // Distance from the top set bit of P[46:0] up to bit 46
        for (int i = 0; i < 47; i++) begin
            if (w_p[i]) begin
                w_lz = 12'(46 - i);
            end
        end

        if (w_p[47]) begin
            w_p = w_p >> 1;
            w_e = w_e + 12'sd1;
        end else if (w_e > 12'sd1) begin
            // Normalise left but never below exponent 1; what remains is a subnormal
            w_sh = (w_lz < (w_e - 12'sd1)) ? w_lz : (w_e - 12'sd1);
            w_p  = w_p << w_sh;
            w_e  = w_e - w_sh;
        end

        // Denormalise into the subnormal range; shift amount is always positive here
        if (w_e < 12'sd1) begin
            w_p = w_p >> (12'sd1 - w_e);
            w_e = '0;
        end

        if (w_nan_a || w_nan_b) begin
            w_res = 32'hFFFF_FFFF;
        end else if ((w_inf_a && w_zero_b) || (w_inf_b && w_zero_a)) begin
            w_res = 32'hFFFF_FFFF;
        end else if (w_inf_a || w_inf_b) begin
            w_res = {w_s, 8'hFF, 23'd0};
        end else if (w_zero_a || w_zero_b || w_flush) begin
            w_res = {w_s, 31'd0};
        end else if (w_e >= 12'sd255) begin
            // Overflow saturates to Inf even though rounding is toward zero
            w_res = {w_s, 8'hFF, 23'd0};
        end else begin
            // Hidden bit clear means the value ended up subnormal: exponent field 0
            w_res = {w_s, (w_p[46] ? w_e[7:0] : 8'h00), w_p[45:23]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
        end else begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_res <= w_res;
        end
    end

    assign o_res = r_res;

endmodule

// File: tb/tb_floating_mult.sv
// Self-checking bench for floating_mult: directed vectors with fixed expected results,
// then randomized operands checked against a real-arithmetic reference model.
// Results are expected exactly 2 cycles after the operands are applied.
module tb_floating_mult;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [31:0] o_res;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    floating_mult dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_res   (o_res)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Directed vectors with hand-derived products
    localparam int NDIR = 14;
    logic [31:0] dir_a   [NDIR] = '{32'hC000_0000, 32'h4060_0000, 32'h420C_B122, 32'h0000_1001,
                                    32'h0060_0000, 32'h8040_0000, 32'h0000_0002, 32'hA000_0002,
                                    32'h4091_EB85, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7F80_0000,
                                    32'hFF80_0000, 32'h8000_0000};
    logic [31:0] dir_b   [NDIR] = '{32'h3E00_0000, 32'h425D_0000, 32'h4479_E472, 32'h4040_0000,
                                    32'h405D_0000, 32'h4060_0000, 32'h80FF_FFFF, 32'h947F_FFFF,
                                    32'h7F40_0000, 32'hFF80_0000, 32'h7F80_0000, 32'h80FF_FFFF,
                                    32'hFF80_0000, 32'h8000_0000};
    logic [31:0] dir_exp [NDIR] = '{32'hBE80_0000, 32'h4341_6000, 32'h4709_55D6, 32'h0000_3003,
                                    32'h0125_C000, 32'h80E0_0000, 32'h8000_0000, 32'h0000_0000,
                                    32'h7F80_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFF80_0000,
                                    32'h7F80_0000, 32'h0000_0000};

    // ---------------- reference model ----------------
    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) r = r * 0.5;
        end
        return r;
    endfunction

    function automatic real op_val(input logic [31:0] x);
        int e;
        e = int'(x[30:23]);
        if (e == 0) return real'(int'(x[22:0])) * pow2(-149);
        return real'(int'(x[22:0]) + (1 << 23)) * pow2(e - 150);
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        int   ea, eb, ka, kb, k, fr;
        real  pr, m;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        inf_a  = (ea == 255) && (a[22:0] == 0);
        inf_b  = (eb == 255) && (b[22:0] == 0);
        zero_a = (ea == 0) && (a[22:0] == 0);
        zero_b = (eb == 0) && (b[22:0] == 0);
        if (nan_a || nan_b) return 32'hFFFF_FFFF;
        if ((inf_a && zero_b) || (inf_b && zero_a)) return 32'hFFFF_FFFF;
        if (inf_a || inf_b) return {s, 8'hFF, 23'h0};
        // Exponent-sum flush: taken even when the exact product reaches the smallest subnormal
        ka = (ea == 0) ? 1 : ea;
        kb = (eb == 0) ? 1 : eb;
        if (ka + kb - 127 <= -23) return {s, 31'h0};
        pr = op_val(a) * op_val(b);
        if (pr == 0.0) return {s, 31'h0};
        if (pr >= pow2(128)) return {s, 8'hFF, 23'h0};
        if (pr < pow2(-126)) begin
            fr = $rtoi($floor(pr * pow2(149)));
            return {s, 8'h00, fr[22:0]};
        end
        m = pr;
        k = 0;
        while (m >= 2.0) begin m = m * 0.5; k++; end
        while (m < 1.0)  begin m = m * 2.0; k--; end
        fr = $rtoi($floor((m - 1.0) * pow2(23)));
        k  = k + 127;
        return {s, k[7:0], fr[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int          c;
        logic [7:0]  e;
        logic [22:0] f;
        c = int'($urandom_range(0, 9));
        f = 23'($urandom());
        case (c)
            0:       e = 8'h00;
            1:       begin e = 8'h00; f = '0; end
            2:       e = 8'hFF;
            3:       begin e = 8'hFF; f = '0; end
            4:       e = 8'($urandom_range(0, 255));
            5:       e = 8'($urandom_range(1, 40));
            6:       e = 8'($urandom_range(90, 140));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom()), e, f};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    // One cycle of streaming: check the result of the operands applied two cycles ago,
    // then apply the next operand pair.
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input string tag);
        @(posedge i_clk);
        #1;
        if (exp_q.size() == 2) check(tag_q.pop_front(), o_res, exp_q.pop_front());
        i_a = a;
        i_b = b;
        exp_q.push_back(expv);
        tag_q.push_back($sformatf("%s a=%h b=%h", tag, a, b));
    endtask

    // After reset release: stage 1 holds zeros, the held inputs are captured next
    task automatic restart_pipe();
        exp_q.delete();
        tag_q.delete();
        exp_q.push_back(32'h0);
        tag_q.push_back("post_reset_bubble");
        exp_q.push_back(ref_mul(i_a, i_b));
        tag_q.push_back($sformatf("held_input a=%h b=%h", i_a, i_b));
    endtask

    initial begin
        logic [31:0] ra, rb;
        i_rst_n = 1'b0;
        i_a     = 32'h4060_0000;
        i_b     = 32'h425D_0000;

        #3;
        check("reset_t0", o_res, 32'h0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check("reset_hold", o_res, 32'h0);
        i_rst_n = 1'b1;
        restart_pipe();

        for (int i = 0; i < NDIR; i++) step(dir_a[i], dir_b[i], dir_exp[i], $sformatf("dir%0d", i));

        // Boundary cases checked against the model
        step(32'h7F7F_FFFF, 32'h3F80_0000, ref_mul(32'h7F7F_FFFF, 32'h3F80_0000), "maxnorm_x1");
        step(32'h7F7F_FFFF, 32'h4000_0000, ref_mul(32'h7F7F_FFFF, 32'h4000_0000), "maxnorm_x2");
        step(32'h0080_0000, 32'h3F00_0000, ref_mul(32'h0080_0000, 32'h3F00_0000), "minnorm_half");
        step(32'h0000_0001, 32'h3F7F_FFFF, ref_mul(32'h0000_0001, 32'h3F7F_FFFF), "sub_trunc_zero");
        step(32'h0000_0001, 32'hFF80_0000, ref_mul(32'h0000_0001, 32'hFF80_0000), "sub_x_inf");
        step(32'h807F_FFFF, 32'h4B00_0000, ref_mul(32'h807F_FFFF, 32'h4B00_0000), "sub_to_norm");

        // Mid-stream asynchronous reset with a nonzero result on the output
        step(32'h4060_0000, 32'h425D_0000, 32'h4341_6000, "pre_rst0");
        step(32'h4060_0000, 32'h425D_0000, 32'h4341_6000, "pre_rst1");
        step(32'h4060_0000, 32'h425D_0000, 32'h4341_6000, "pre_rst2");
        i_rst_n = 1'b0;
        #1;
        check("async_reset", o_res, 32'h0);
        @(posedge i_clk);
        #1;
        check("reset_hold2", o_res, 32'h0);
        i_rst_n = 1'b1;
        restart_pipe();

        for (int i = 0; i < 300; i++) begin
            ra = rand_op();
            rb = rand_op();
            step(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d", i));
        end

        step(32'h0, 32'h0, 32'h0, "drain0");
        step(32'h0, 32'h0, 32'h0, "drain1");
        step(32'h0, 32'h0, 32'h0, "drain2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
